mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of EX; consumes its registered control bits, accumulator result, zero flag, jump target, rs value and destination register.
- Holds the EX/MEM pipeline register and the 8-bit data memory with configurable access latency.
- Resolves J/JC branches (pc_src, target, flush) and produces the MEM/WB register plus the forwarding value fed back to EX's dataMem input.

Parameters:
DEPTH, 256, data memory words (8-bit each); address = rs modulo DEPTH
MEM_LAT, 1, cycles per load/store (1..7); >1 stalls upstream
PROT_BASE, 8'hF0, first read-only address (used only with MEM_PROT_EN)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
wr_in  in  1  register write enable from EX
wm_in  in  1  memory write (store)
rm_in  in  1  memory read (load)
neq_in  in  1  JC sense: 1 = branch if not zero
j_in  in  1  unconditional jump
jc_in  in  1  conditional jump
zero_in  in  1  ALU zero flag
acout_in  in  8  accumulator result; store data / WB data
jtarget_in  in  8  PC + offset from EX jump adder
rs_in  in  8  memory address
rd_in  in  2  destination register
stall  out  1  hold EX and earlier stages
pc_src  out  1  1 = fetch from jump_target
jump_target  out  8  branch target
flush  out  1  squash IF/ID/EX contents
fwd_data  out  8  forwarding value (MEM/WB data) to EX
wb_we  out  1  register file write enable
wb_rd  out  2  register file address
wb_data  out  8  register file write data
prot_fault  out  1  sticky protection fault (tied 0 without MEM_PROT_EN)

Behaviour:
- Reset (reset_n=0, async): stage reg all 0, MEM/WB reg all 0, wait counter 0, state IDLE, prot_fault 0; therefore stall, pc_src, flush, wb_we = 0, jump_target, wb_data, fwd_data = 0, wb_rd = 0. Memory contents not reset.
- Stage reg: latches all *_in on rising edge when stall=0; holds when stall=1.
- mem_op = stage.wm | stage.rm.
- FSM IDLE/WAIT: in IDLE, a mem_op with MEM_LAT>1 asserts stall combinationally and moves to WAIT at the edge; cnt counts 1..MEM_LAT-1; stall stays 1 until cnt = MEM_LAT-1. In that final cycle stall=0, the access completes at the edge, and the FSM returns to IDLE. With MEM_LAT=1, stall is never asserted.
- Store: mem[rs] <= acout at the completing edge only.
- Load: wb_data <= mem[rs] at the completing edge.
- Non-load ops: wb_data <= stage.acout.
- Load and store together: store wins the memory write; load returns the old value.
- MEM/WB reg updates only at completing edges: wb_we <= stage.wr, wb_rd <= stage.rd. While stall=1, a bubble is loaded (wb_we=0).
- Latency with MEM_LAT=1: inputs present before edge N; wb_* valid after edge N+1.
- fwd_data = wb_data, combinational.
- Branch, combinational from stage reg: taken = j | (jc & (neq ? ~zero : zero)).
  - pc_src = flush = taken.
  - jump_target = stage.jtarget, always driven.
  - j has priority over jc; taken branches write nothing to memory.
- Reset asserted mid-WAIT: access abandoned, no memory write, FSM to IDLE.

Optional Feature:
MEM_PROT_EN:
- Defined: a store with rs >= PROT_BASE is suppressed (memory unchanged) and prot_fault is set at the completing edge. prot_fault is sticky until reset. Loads are unaffected. wb_we follows wr as normal.
- Undefined: all addresses are writable and prot_fault is tied 0.

Test Plan:
- Reset then store, MEM_LAT=1: wm=1, rs=8'h10, acout=8'h5A; next op rm=1, wr=1, rs=8'h10, rd=2 -> wb_we=1, wb_rd=2, wb_data=8'h5A two edges after the load is presented; stall never 1.
- MEM_LAT=3 load: mem[8'h20]=8'h33, rm=1 -> stall=1 for exactly 2 cycles, inputs held, wb_we=0 bubbles, then wb_data=8'h33.
- Branch: jc=1, neq=1, zero=0, jtarget=8'h44 -> pc_src=1, flush=1, jump_target=8'h44 same cycle; with zero=1 -> pc_src=0. j=1 -> taken regardless of zero.
- Reset mid-WAIT: MEM_LAT=4, store acout=8'hAA to 8'h30; pulse reset_n low in cycle 2 of the wait -> stall=0 immediately, mem[8'h30] unchanged on later load.
- ALU pass-through: wr=1, rd=1, acout=8'h7F, no mem op -> wb_data=fwd_data=8'h7F, wb_we=1 after one edge past latching.
- MEM_PROT_EN: store 8'h11 to 8'hF5 -> prot_fault=1 and stays 1; load 8'hF5 returns the prior value; store to 8'hEF succeeds.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, latency-configurable 8-bit data memory, J/JC resolve.
// Optional MEM_PROT_EN: stores at rs >= PROT_BASE are dropped and set sticky prot_fault.
module mem_stage #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned MEM_LAT   = 1,
   parameter logic [7:0]  PROT_BASE = 8'hF0
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       wr_in,
   input  logic       wm_in,
   input  logic       rm_in,
   input  logic       neq_in,
   input  logic       j_in,
   input  logic       jc_in,
   input  logic       zero_in,
   input  logic [7:0] acout_in,
   input  logic [7:0] jtarget_in,
   input  logic [7:0] rs_in,
   input  logic [1:0] rd_in,
   output logic       stall,
   output logic       pc_src,
   output logic [7:0] jump_target,
   output logic       flush,
   output logic [7:0] fwd_data,
   output logic       wb_we,
   output logic [1:0] wb_rd,
   output logic [7:0] wb_data,
   output logic       prot_fault
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0]  LAST = 3'(MEM_LAT - 1);

   typedef struct packed {
      logic       wr;
      logic       wm;
      logic       rm;
      logic       neq;
      logic       j;
      logic       jc;
      logic       zero;
      logic [7:0] acout;
      logic [7:0] jtarget;
      logic [7:0] rs;
      logic [1:0] rd;
   } stg_t;

   typedef enum logic {IDLE, WAIT} state_t;

   stg_t          r_stg;
   state_t        r_state;
   logic [2:0]    r_cnt;
   logic          r_wb_we;
   logic [1:0]    r_wb_rd;
   logic [7:0]    r_wb_data;
   logic [7:0]    r_mem [DEPTH];

   stg_t          w_in;
   logic          w_mem_op;
   logic          w_taken;
   logic          w_stall;
   logic          w_done;
   logic          w_prot_hit;
   logic          w_store;
   logic [AW-1:0] w_addr;

   assign w_in = '{wr: wr_in, wm: wm_in, rm: rm_in, neq: neq_in,
                   j: j_in, jc: jc_in, zero: zero_in, acout: acout_in,
                   jtarget: jtarget_in, rs: rs_in, rd: rd_in};

   assign w_mem_op = r_stg.wm | r_stg.rm;
   assign w_taken  = r_stg.j |
                     (r_stg.jc & (r_stg.neq ? ~r_stg.zero : r_stg.zero));
   assign w_addr   = AW'(32'(r_stg.rs) % DEPTH);

   always_comb begin
      w_stall = 1'b0;
      if (MEM_LAT > 1) begin
         if (r_state == IDLE) w_stall = w_mem_op;
         else                 w_stall = (r_cnt != LAST);
      end
   end

   // every non-stalled edge retires the op held in the stage register
   assign w_done = ~w_stall;

`ifdef MEM_PROT_EN
   logic r_prot;
   assign w_prot_hit = (r_stg.rs >= PROT_BASE);
   assign prot_fault = r_prot;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_prot <= 1'b0;
      end else if (w_done && r_stg.wm && !w_taken && w_prot_hit) begin
         r_prot <= 1'b1;
      end
   end
`else
   assign w_prot_hit = 1'b0;
   assign prot_fault = 1'b0;
`endif

   assign w_store = r_stg.wm & ~w_taken & ~w_prot_hit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_stg     <= '0;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_wb_we   <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else begin
         if (!w_stall) r_stg <= w_in;
         unique case (r_state)
            IDLE: begin
               if (w_mem_op && MEM_LAT > 1) begin
                  r_state <= WAIT;
                  r_cnt   <= 3'd1;
               end
            end
            WAIT: begin
               if (r_cnt == LAST) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
         endcase
         if (w_done) begin
            r_wb_we   <= r_stg.wr;
            r_wb_rd   <= r_stg.rd;
            r_wb_data <= r_stg.rm ? r_mem[w_addr] : r_stg.acout;
         end else begin
            r_wb_we <= 1'b0;
         end
      end
   end

   // memory is deliberately not reset; a reset clears r_stg so no write follows
   always_ff @(posedge clock) begin
      if (w_done && w_store) r_mem[w_addr] <= r_stg.acout;
   end

   assign stall       = w_stall;
   assign pc_src      = w_taken;
   assign flush       = w_taken;
   assign jump_target = r_stg.jtarget;
   assign wb_we       = r_wb_we;
   assign wb_rd       = r_wb_rd;
   assign wb_data     = r_wb_data;
   assign fwd_data    = r_wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances at MEM_LAT 1, 3 and 4 share one input bus.
module tb_mem_stage;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr, wm, rm, neq, j, jc, zero;
   logic [7:0] ac, jt, rs;
   logic [1:0] rd;

   logic       s1, pc1, fl1, we1, pf1;
   logic [7:0] jt1, fw1, d1;
   logic [1:0] rd1;
   logic       s3, pc3, fl3, we3, pf3;
   logic [7:0] jt3, fw3, d3;
   logic [1:0] rd3;
   logic       s4, pc4, fl4, we4, pf4;
   logic [7:0] jt4, fw4, d4;
   logic [1:0] rd4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   mem_stage #(.MEM_LAT(1)) u1 (
      .clock(clock), .reset_n(reset_n), .wr_in(wr), .wm_in(wm), .rm_in(rm),
      .neq_in(neq), .j_in(j), .jc_in(jc), .zero_in(zero), .acout_in(ac),
      .jtarget_in(jt), .rs_in(rs), .rd_in(rd), .stall(s1), .pc_src(pc1),
      .jump_target(jt1), .flush(fl1), .fwd_data(fw1), .wb_we(we1),
      .wb_rd(rd1), .wb_data(d1), .prot_fault(pf1));

   mem_stage #(.MEM_LAT(3)) u3 (
      .clock(clock), .reset_n(reset_n), .wr_in(wr), .wm_in(wm), .rm_in(rm),
      .neq_in(neq), .j_in(j), .jc_in(jc), .zero_in(zero), .acout_in(ac),
      .jtarget_in(jt), .rs_in(rs), .rd_in(rd), .stall(s3), .pc_src(pc3),
      .jump_target(jt3), .flush(fl3), .fwd_data(fw3), .wb_we(we3),
      .wb_rd(rd3), .wb_data(d3), .prot_fault(pf3));

   mem_stage #(.MEM_LAT(4)) u4 (
      .clock(clock), .reset_n(reset_n), .wr_in(wr), .wm_in(wm), .rm_in(rm),
      .neq_in(neq), .j_in(j), .jc_in(jc), .zero_in(zero), .acout_in(ac),
      .jtarget_in(jt), .rs_in(rs), .rd_in(rd), .stall(s4), .pc_src(pc4),
      .jump_target(jt4), .flush(fl4), .fwd_data(fw4), .wb_we(we4),
      .wb_rd(rd4), .wb_data(d4), .prot_fault(pf4));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_op(input logic i_wr, i_wm, i_rm, i_neq, i_j, i_jc, i_zero,
                         input logic [7:0] i_ac, i_jt, i_rs, input logic [1:0] i_rd);
      wr = i_wr; wm = i_wm; rm = i_rm; neq = i_neq; j = i_j; jc = i_jc;
      zero = i_zero; ac = i_ac; jt = i_jt; rs = i_rs; rd = i_rd;
   endtask

   task automatic bubble();
      set_op(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
   endtask

   task automatic apply_reset();
      bubble();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   // latch the driven op, then keep it on the bus while the chosen instance stalls
   task automatic issue(input int sel, output int stalls, output logic saw_we);
      stalls = 0;
      saw_we = 1'b0;
      step();
      while ((sel == 3) ? s3 : s4) begin
         if (stalls > 0 && ((sel == 3) ? we3 : we4)) saw_we = 1'b1;
         stalls++;
         if (stalls > 20) break;
         step();
      end
   endtask

   task automatic do_store(input logic [7:0] a, input logic [7:0] v);
      set_op(0, 1, 0, 0, 0, 0, 0, v, 8'h00, a, 2'd0);
      step();
      bubble();
      step();
   endtask

   task automatic do_load(input logic [7:0] a, output logic [7:0] v);
      set_op(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, a, 2'd1);
      step();
      bubble();
      step();
      v = d1;
   endtask

   task automatic test_reset();
      bubble();
      reset_n = 1'b0;
      #2;
      n_tests++; if (s1 !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", s1); end
      n_tests++; if ({pc1, fl1} !== 2'b00) begin n_fail++; $display("FAIL rst_pcsrc_flush got %b want 00", {pc1, fl1}); end
      n_tests++; if (we1 !== 1'b0 || rd1 !== 2'd0) begin n_fail++; $display("FAIL rst_wb got we=%b rd=%0d want 0/0", we1, rd1); end
      n_tests++; if ({jt1, d1, fw1} !== 24'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", {jt1, d1, fw1}); end
      n_tests++; if (pf1 !== 1'b0) begin n_fail++; $display("FAIL rst_prot got %b want 0", pf1); end
      n_tests++; if ({s3, s4} !== 2'b00) begin n_fail++; $display("FAIL rst_stall_slow got %b want 00", {s3, s4}); end
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_store_load();
      apply_reset();
      set_op(0, 1, 0, 0, 0, 0, 0, 8'h5A, 8'h00, 8'h10, 2'd0);
      step();
      n_tests++; if (s1 !== 1'b0) begin n_fail++; $display("FAIL sl_stall_st got %b want 0", s1); end
      set_op(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 2'd2);
      step();
      n_tests++; if (s1 !== 1'b0 || we1 !== 1'b0) begin n_fail++; $display("FAIL sl_mid got stall=%b we=%b want 0/0", s1, we1); end
      bubble();
      step();
      n_tests++; if (we1 !== 1'b1 || rd1 !== 2'd2) begin n_fail++; $display("FAIL sl_wb got we=%b rd=%0d want 1/2", we1, rd1); end
      n_tests++; if (d1 !== 8'h5A || fw1 !== 8'h5A) begin n_fail++; $display("FAIL sl_data got %h/%h want 5a", d1, fw1); end
   endtask

   task automatic test_lat3_load();
      int   n;
      logic w;
      apply_reset();
      set_op(0, 1, 0, 0, 0, 0, 0, 8'h33, 8'h00, 8'h20, 2'd0);
      issue(3, n, w);
      n_tests++; if (n !== 2) begin n_fail++; $display("FAIL l3_st_stalls got %0d want 2", n); end
      set_op(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h5C, 8'h20, 2'd3);
      issue(3, n, w);
      n_tests++; if (n !== 2) begin n_fail++; $display("FAIL l3_ld_stalls got %0d want 2", n); end
      n_tests++; if (w !== 1'b0) begin n_fail++; $display("FAIL l3_bubble got we=%b want 0", w); end
      n_tests++; if (jt3 !== 8'h5C) begin n_fail++; $display("FAIL l3_held got %h want 5c", jt3); end
      bubble();
      step();
      n_tests++; if (we3 !== 1'b1 || rd3 !== 2'd3) begin n_fail++; $display("FAIL l3_wb got we=%b rd=%0d want 1/3", we3, rd3); end
      n_tests++; if (d3 !== 8'h33 || fw3 !== 8'h33) begin n_fail++; $display("FAIL l3_data got %h/%h want 33", d3, fw3); end
      n_tests++; if (s3 !== 1'b0) begin n_fail++; $display("FAIL l3_stall_end got %b want 0", s3); end
   endtask

   task automatic test_branch();
      logic [7:0] v;
      apply_reset();
      do_store(8'h50, 8'h12);
      set_op(0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h44, 8'h00, 2'd0);
      step();
      n_tests++; if ({pc1, fl1} !== 2'b11 || jt1 !== 8'h44) begin n_fail++; $display("FAIL br_jc_neq got %b %h want 11 44", {pc1, fl1}, jt1); end
      set_op(0, 0, 0, 1, 0, 1, 1, 8'h00, 8'h44, 8'h00, 2'd0);
      step();
      n_tests++; if ({pc1, fl1} !== 2'b00 || jt1 !== 8'h44) begin n_fail++; $display("FAIL br_jc_nt got %b %h want 00 44", {pc1, fl1}, jt1); end
      set_op(0, 0, 0, 1, 1, 1, 1, 8'h00, 8'h9A, 8'h00, 2'd0);
      step();
      n_tests++; if (pc1 !== 1'b1 || jt1 !== 8'h9A) begin n_fail++; $display("FAIL br_j got %b %h want 1 9a", pc1, jt1); end
      set_op(0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h21, 8'h00, 2'd0);
      step();
      n_tests++; if (fl1 !== 1'b1) begin n_fail++; $display("FAIL br_jc_eq got %b want 1", fl1); end
      set_op(0, 1, 0, 0, 1, 0, 0, 8'hEE, 8'h60, 8'h50, 2'd0);
      step();
      n_tests++; if (pc1 !== 1'b1) begin n_fail++; $display("FAIL br_j_st got %b want 1", pc1); end
      do_load(8'h50, v);
      n_tests++; if (v !== 8'h12) begin n_fail++; $display("FAIL br_nowrite got %h want 12", v); end
   endtask

   task automatic test_reset_mid_wait();
      int   n;
      logic w;
      apply_reset();
      set_op(0, 1, 0, 0, 0, 0, 0, 8'h55, 8'h00, 8'h30, 2'd0);
      issue(4, n, w);
      n_tests++; if (n !== 3) begin n_fail++; $display("FAIL rw_stalls got %0d want 3", n); end
      bubble();
      step();
      set_op(0, 1, 0, 0, 0, 0, 0, 8'hAA, 8'h00, 8'h30, 2'd0);
      step();
      n_tests++; if (s4 !== 1'b1) begin n_fail++; $display("FAIL rw_stall_on got %b want 1", s4); end
      step();
      bubble();
      reset_n = 1'b0;
      #1;
      n_tests++; if (s4 !== 1'b0 || we4 !== 1'b0) begin n_fail++; $display("FAIL rw_abort got stall=%b we=%b want 0/0", s4, we4); end
      #1;
      reset_n = 1'b1;
      set_op(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h30, 2'd1);
      issue(4, n, w);
      bubble();
      step();
      n_tests++; if (d4 !== 8'h55 || we4 !== 1'b1) begin n_fail++; $display("FAIL rw_mem got %h we=%b want 55/1", d4, we4); end
   endtask

   task automatic test_passthrough();
      apply_reset();
      set_op(1, 0, 0, 0, 0, 0, 0, 8'h7F, 8'h00, 8'h00, 2'd1);
      step();
      n_tests++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL pt_early got we=%b want 0", we1); end
      bubble();
      step();
      n_tests++; if (we1 !== 1'b1 || rd1 !== 2'd1) begin n_fail++; $display("FAIL pt_wb got we=%b rd=%0d want 1/1", we1, rd1); end
      n_tests++; if (d1 !== 8'h7F || fw1 !== 8'h7F) begin n_fail++; $display("FAIL pt_data got %h/%h want 7f", d1, fw1); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      apply_reset();
      set_op(1, 0, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h00, 2'd0);
      step();
      set_op(1, 0, 0, 0, 0, 0, 0, 8'h02, 8'h00, 8'h00, 2'd3);
      step();
      n_tests++; if ({we1, rd1, d1} !== {1'b1, 2'd0, 8'h01}) begin n_fail++; $display("FAIL bb_op1 got %b/%0d/%h want 1/0/01", we1, rd1, d1); end
      set_op(0, 1, 0, 0, 0, 0, 0, 8'h77, 8'h00, 8'h40, 2'd0);
      step();
      n_tests++; if ({we1, rd1, d1} !== {1'b1, 2'd3, 8'h02}) begin n_fail++; $display("FAIL bb_op2 got %b/%0d/%h want 1/3/02", we1, rd1, d1); end
      set_op(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h40, 2'd2);
      step();
      n_tests++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL bb_store_we got %b want 0", we1); end
      bubble();
      step();
      n_tests++; if ({we1, rd1, d1} !== {1'b1, 2'd2, 8'h77}) begin n_fail++; $display("FAIL bb_load got %b/%0d/%h want 1/2/77", we1, rd1, d1); end
      do_store(8'h60, 8'h01);
      set_op(1, 1, 1, 0, 0, 0, 0, 8'h02, 8'h00, 8'h60, 2'd1);
      step();
      bubble();
      step();
      n_tests++; if (d1 !== 8'h01) begin n_fail++; $display("FAIL bb_ldst_old got %h want 01", d1); end
      do_load(8'h60, v);
      n_tests++; if (v !== 8'h02) begin n_fail++; $display("FAIL bb_ldst_new got %h want 02", v); end
   endtask

   task automatic test_prot();
      logic [7:0] v;
      logic [7:0] v0;
      apply_reset();
`ifdef MEM_PROT_EN
      do_load(8'hF5, v0);
      do_store(8'hF5, 8'h11);
      n_tests++; if (pf1 !== 1'b1) begin n_fail++; $display("FAIL pr_set got %b want 1", pf1); end
      step();
      step();
      n_tests++; if (pf1 !== 1'b1) begin n_fail++; $display("FAIL pr_sticky got %b want 1", pf1); end
      do_load(8'hF5, v);
      n_tests++; if (v !== v0) begin n_fail++; $display("FAIL pr_unchanged got %h want %h", v, v0); end
`else
      v0 = 8'h11;
      do_store(8'hF5, 8'h11);
      do_load(8'hF5, v);
      n_tests++; if (v !== v0) begin n_fail++; $display("FAIL pr_open got %h want %h", v, v0); end
      n_tests++; if (pf1 !== 1'b0) begin n_fail++; $display("FAIL pr_tied got %b want 0", pf1); end
`endif
      do_store(8'hEF, 8'h66);
      do_load(8'hEF, v);
      n_tests++; if (v !== 8'h66) begin n_fail++; $display("FAIL pr_ef got %h want 66", v); end
   endtask

   initial begin
      bubble();
      test_reset();
      test_store_load();
      test_lat3_load();
      test_branch();
      test_reset_mid_wait();
      test_passthrough();
      test_back_to_back();
      test_prot();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
